// File: rtl/comparador_dms_pkg.sv
// Shared defaults and the decision type for the comparador_dms behavioural comparator.
package comparador_dms_pkg;
  localparam real VOH_DEF = 1.0;
  localparam real VOL_DEF = 0.0;
  localparam int  DEB_MAX = 255;

  typedef logic decision_t;
endpackage

// File: rtl/comparador_dms_filter.sv
// Debounce filter: a candidate must disagree with the held state for DEB_CYC
// consecutive edges before the state follows it.
import comparador_dms_pkg::*;

module comparador_dms_filter #(
  parameter int DEB_CYC = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  decision_t cand,
  output decision_t state
);
  // Out-of-range settings are clamped so the 8-bit counter can never wrap.
  localparam int         DEB_EFF = (DEB_CYC < 1) ? 1 : ((DEB_CYC > DEB_MAX) ? DEB_MAX : DEB_CYC);
  localparam logic [8:0] LIM     = 9'(DEB_EFF);

  logic [7:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (cand == state) begin
      cnt <= '0;
    end else if (({1'b0, cnt} + 9'd1) >= LIM) begin
      state <= cand;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/comparador_dms.sv
// Behavioural mixed-signal comparator: real-valued hysteresis threshold feeding
// a registered debounce filter, output mapped to VOH/VOL levels.
import comparador_dms_pkg::*;

module comparador_dms #(
  parameter real HYST_V  = 0.0,
  parameter int  DEB_CYC = 1,
  parameter real VOH     = VOH_DEF,
  parameter real VOL     = VOL_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  real  p_i,
  input  real  n_i,
  output real  c_o,
  output logic c_d_o
);
  real       diff;
  decision_t cand;
  decision_t state;

  // Threshold depends on the held state; with zero hysteresis a tie reads low.
  always_comb begin
    diff = p_i - n_i;
    cand = 1'b0;
    if (state) cand = !(diff <= -(HYST_V / 2.0));
    else       cand = (diff > (HYST_V / 2.0));
  end

  comparador_dms_filter #(.DEB_CYC(DEB_CYC)) u_filter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .cand  (cand),
    .state (state)
  );

  assign c_o   = state ? VOH : VOL;
  assign c_d_o = state;
endmodule

// File: tb/tb_comparador_dms.sv
// Directed and randomized checks of comparador_dms in three parameterizations.
module tb_comparador_dms;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;

  real  p_def = 0.0, n_def = 0.0, c_def;
  logic cd_def;
  real  p_hys = 0.0, n_hys = 0.0, c_hys;
  logic cd_hys;
  real  p_deb = 0.0, n_deb = 0.0, c_deb;
  logic cd_deb;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  comparador_dms u_def (
    .clk_i(clk_i), .rst_ni(rst_ni), .p_i(p_def), .n_i(n_def), .c_o(c_def), .c_d_o(cd_def)
  );
  comparador_dms #(.HYST_V(0.02)) u_hys (
    .clk_i(clk_i), .rst_ni(rst_ni), .p_i(p_hys), .n_i(n_hys), .c_o(c_hys), .c_d_o(cd_hys)
  );
  comparador_dms #(.DEB_CYC(3)) u_deb (
    .clk_i(clk_i), .rst_ni(rst_ni), .p_i(p_deb), .n_i(n_deb), .c_o(c_deb), .c_d_o(cd_deb)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_real(input string tag, input real obs, input real exp);
    n_chk++;
    assert ($realtobits(obs) === $realtobits(exp)) n_pass++;
    else $error("FAIL %s: got %f expected %f", tag, obs, exp);
  endtask

  // Checks both outputs of one instance against an expected decision (levels 1.0/0.0).
  task automatic chk_out(input string tag, input real c, input logic cd, input logic exp);
    chk_real({tag, "_c"}, c, exp ? 1.0 : 0.0);
    chk_bit({tag, "_cd"}, cd, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic hs_exp;
    real  d;

    // Reset with a positive differential applied: outputs held low regardless.
    p_def = 0.05; n_def = 0.00;
    p_deb = 0.05; n_deb = 0.00;
    #1 rst_ni = 1'b0;
    #1;
    chk_out("rst_imm_def", c_def, cd_def, 1'b0);
    chk_out("rst_imm_deb", c_deb, cd_deb, 1'b0);
    step(); step(); step(); step();
    chk_out("rst_hold_def", c_def, cd_def, 1'b0);
    chk_out("rst_hold_hys", c_hys, cd_hys, 1'b0);
    chk_out("rst_hold_deb", c_deb, cd_deb, 1'b0);
    p_def = 0.0; p_deb = 0.0;
    rst_ni = 1'b1;

    // Defaults: single-edge latency, and no combinational path from inputs.
    p_def = 0.04; n_def = 0.01;
    #1 chk_out("def_no_comb", c_def, cd_def, 1'b0);
    step(); chk_out("def_rise", c_def, cd_def, 1'b1);
    p_def = 0.01; n_def = 0.03;
    step(); chk_out("def_fall", c_def, cd_def, 1'b0);
    p_def = 0.04; n_def = 0.01;
    step(); chk_out("def_rise2", c_def, cd_def, 1'b1);
    p_def = 0.02; n_def = 0.02;
    step(); chk_out("def_tie", c_def, cd_def, 1'b0);
    step(); chk_out("def_tie_hold", c_def, cd_def, 1'b0);

    // Hysteresis window of +/-10 mV.
    p_hys = 0.005; n_hys = 0.0;
    step(); chk_out("hys_in_win_lo", c_hys, cd_hys, 1'b0);
    p_hys = 0.01;  n_hys = 0.0;
    step(); chk_out("hys_at_upper", c_hys, cd_hys, 1'b0);
    p_hys = 0.015; n_hys = 0.0;
    step(); chk_out("hys_rise", c_hys, cd_hys, 1'b1);
    p_hys = 0.0;   n_hys = 0.005;
    step(); chk_out("hys_in_win_hi", c_hys, cd_hys, 1'b1);
    p_hys = 0.0;   n_hys = 0.01;
    step(); chk_out("hys_fall_at_lower", c_hys, cd_hys, 1'b0);

    // Debounce of 3: a 2-cycle pulse is rejected, a 3-cycle level passes.
    p_deb = 0.02; n_deb = 0.0;
    step(); chk_out("deb_pulse1", c_deb, cd_deb, 1'b0);
    step(); chk_out("deb_pulse2", c_deb, cd_deb, 1'b0);
    p_deb = 0.0;
    step(); chk_out("deb_pulse_gone1", c_deb, cd_deb, 1'b0);
    step(); chk_out("deb_pulse_gone2", c_deb, cd_deb, 1'b0);
    p_deb = 0.02;
    step(); chk_out("deb_hold1", c_deb, cd_deb, 1'b0);
    step(); chk_out("deb_hold2", c_deb, cd_deb, 1'b0);
    step(); chk_out("deb_hold3", c_deb, cd_deb, 1'b1);
    p_deb = 0.0;
    step(); chk_out("deb_fall1", c_deb, cd_deb, 1'b1);
    step(); chk_out("deb_fall2", c_deb, cd_deb, 1'b1);
    step(); chk_out("deb_fall3", c_deb, cd_deb, 1'b0);

    // Reset in the middle of a count must discard it.
    p_deb = 0.02;
    step(); step();
    rst_ni = 1'b0;
    #1 chk_out("deb_mid_rst", c_deb, cd_deb, 1'b0);
    rst_ni = 1'b1;
    step(); chk_out("deb_after_rst1", c_deb, cd_deb, 1'b0);
    step(); chk_out("deb_after_rst2", c_deb, cd_deb, 1'b0);
    step(); chk_out("deb_after_rst3", c_deb, cd_deb, 1'b1);

    // Random sweep at defaults: decision is simply p > n, ties low.
    for (int i = 0; i < 10; i++) begin
      p_def = real'($urandom_range(0, 5)) * 0.01;
      n_def = real'($urandom_range(0, 5)) * 0.01;
      step();
      chk_out($sformatf("sweep_def%0d", i), c_def, cd_def, p_def > n_def);
    end

    // Random walk through the hysteresis window against a two-threshold model.
    hs_exp = cd_hys === 1'b1;
    for (int i = 0; i < 24; i++) begin
      p_hys = real'($urandom_range(0, 4)) * 0.005;
      n_hys = real'($urandom_range(0, 4)) * 0.005;
      d = p_hys - n_hys;
      hs_exp = hs_exp ? (d > -0.01) : (d > 0.01);
      step();
      chk_bit($sformatf("sweep_hys%0d", i), cd_hys, hs_exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
